// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the IF and
// MEM pipeline stages. One outstanding transaction at a time; data accesses
// win over fetches. Also produces the fetch and pipeline stall signals.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction fetch side
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    // data access side
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_be,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_done,
    // memory side
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    // pipeline control
    output logic                  stall_fetch,
    output logic                  stall_pipe
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH      = 2'd1,
        FETCH_DROP = 2'd2,
        DATA       = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   fetch_ok;
    logic   load_fetch;
    logic   load_data;

    // Read data is shared; the valid/done strobes say who owns it.
    assign if_rdata = mem_rdata;
    assign dm_rdata = mem_rdata;

    // A fetch may only be launched when the PC is not being redirected.
    assign fetch_ok = if_req & ~if_flush;

    // Next-state, completion strobes and stall generation.
    always_comb begin
        state_next  = state;
        if_valid    = 1'b0;
        dm_done     = 1'b0;
        load_fetch  = 1'b0;
        load_data   = 1'b0;
        stall_pipe  = 1'b0;
        stall_fetch = 1'b0;

        case (state)
            IDLE: begin
                if (dm_req) begin
                    state_next = DATA;
                end else if (fetch_ok) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    if_valid   = ~if_flush;
                    state_next = dm_req ? DATA : IDLE;
                end else if (if_flush) begin
                    state_next = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (mem_ack) begin
                    if (dm_req) begin
                        state_next = DATA;
                    end else if (fetch_ok) begin
                        state_next = FETCH;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (mem_ack) begin
                    dm_done    = 1'b1;
                    state_next = fetch_ok ? FETCH : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        load_fetch  = (state_next == FETCH) && (state != FETCH);
        load_data   = (state_next == DATA) && (state != DATA);
        stall_pipe  = dm_req & ~dm_done;
        stall_fetch = stall_pipe | (if_req & ~if_valid);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory request registers: loaded on entry to an access, held until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else if (load_data) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
        end else if (load_fetch) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
        end else if (state_next == IDLE) begin
            mem_req   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_be;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        if_valid, dm_done, mem_req, mem_we, stall_fetch, stall_pipe;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .stall_fetch(stall_fetch), .stall_pipe(stall_pipe)
    );

    typedef struct {
        // inputs
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        if_flush;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [3:0]  dm_be;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        // expected outputs (memory fields checked when e_req or full)
        logic        full;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_iv;
        logic        e_dd;
        logic        e_sp;
        logic        e_sf;
    } vec_t;

    vec_t tbl[21];

    // reference model: one outstanding access, described as a transaction
    bit          m_busy, m_data, m_stale, m_zero;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        rst = v.rst; if_req = v.if_req; if_addr = v.if_addr; if_flush = v.if_flush;
        dm_req = v.dm_req; dm_we = v.dm_we; dm_addr = v.dm_addr;
        dm_wdata = v.dm_wdata; dm_be = v.dm_be;
        mem_ack = v.mem_ack; mem_rdata = v.mem_rdata;
        #2;
        chk($sformatf("vec%0d_mem_req", idx), 32'(mem_req), 32'(v.e_req));
        chk($sformatf("vec%0d_if_valid", idx), 32'(if_valid), 32'(v.e_iv));
        chk($sformatf("vec%0d_dm_done", idx), 32'(dm_done), 32'(v.e_dd));
        chk($sformatf("vec%0d_stall_pipe", idx), 32'(stall_pipe), 32'(v.e_sp));
        chk($sformatf("vec%0d_stall_fetch", idx), 32'(stall_fetch), 32'(v.e_sf));
        if (v.e_req || v.full) begin
            chk($sformatf("vec%0d_mem_addr", idx), mem_addr, v.e_addr);
            chk($sformatf("vec%0d_mem_we", idx), 32'(mem_we), 32'(v.e_we));
            chk($sformatf("vec%0d_mem_be", idx), 32'(mem_be), 32'(v.e_be));
        end
        if (v.full || (v.e_req && v.e_we))
            chk($sformatf("vec%0d_mem_wdata", idx), mem_wdata, v.e_wdata);
        if (v.e_iv) chk($sformatf("vec%0d_if_rdata", idx), if_rdata, v.mem_rdata);
        if (v.e_dd) chk($sformatf("vec%0d_dm_rdata", idx), dm_rdata, v.mem_rdata);
        next_cycle();
    endtask

    task automatic model_reset();
        m_busy = 0; m_data = 0; m_stale = 0; m_zero = 1;
        m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
    endtask

    // Compare this cycle's outputs against the model's view of the access.
    task automatic model_check(input int cyc);
        bit e_iv, e_dd, e_sp, e_sf;
        e_iv = m_busy && !m_data && !m_stale && mem_ack && !if_flush;
        e_dd = m_busy && m_data && mem_ack;
        e_sp = dm_req && !e_dd;
        e_sf = e_sp || (if_req && !e_iv);
        chk($sformatf("rnd%0d_if_valid", cyc), 32'(if_valid), 32'(e_iv));
        chk($sformatf("rnd%0d_dm_done", cyc), 32'(dm_done), 32'(e_dd));
        chk($sformatf("rnd%0d_stall_pipe", cyc), 32'(stall_pipe), 32'(e_sp));
        chk($sformatf("rnd%0d_stall_fetch", cyc), 32'(stall_fetch), 32'(e_sf));
        chk($sformatf("rnd%0d_mem_req", cyc), 32'(mem_req), 32'(m_busy));
        chk($sformatf("rnd%0d_if_rdata", cyc), if_rdata, mem_rdata);
        chk($sformatf("rnd%0d_dm_rdata", cyc), dm_rdata, mem_rdata);
        if (m_busy) begin
            chk($sformatf("rnd%0d_mem_addr", cyc), mem_addr, m_addr);
            chk($sformatf("rnd%0d_mem_we", cyc), 32'(mem_we), 32'(m_we));
            chk($sformatf("rnd%0d_mem_be", cyc), 32'(mem_be), 32'(m_be));
            if (m_data) chk($sformatf("rnd%0d_mem_wdata", cyc), mem_wdata, m_wdata);
        end
        if (m_zero) begin
            chk($sformatf("rnd%0d_rst_addr", cyc), mem_addr, 32'h0);
            chk($sformatf("rnd%0d_rst_wdata", cyc), mem_wdata, 32'h0);
            chk($sformatf("rnd%0d_rst_ctl", cyc), {27'h0, mem_we, mem_be}, 32'h0);
        end
    endtask

    // Advance the model by one clock: the finishing owner may not re-issue
    // immediately; otherwise data beats fetch, and flushes block new fetches.
    task automatic model_step();
        bit free, prev_data, prev_live_fetch;
        if (rst) begin
            model_reset();
            return;
        end
        free            = !m_busy || mem_ack;
        prev_data       = m_busy && m_data;
        prev_live_fetch = m_busy && !m_data && !m_stale;
        if (m_busy && !mem_ack && !m_data && if_flush) m_stale = 1;
        if (free) begin
            if (dm_req && !prev_data) begin
                m_busy = 1; m_data = 1; m_stale = 0; m_zero = 0;
                m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_be = dm_be;
            end else if (if_req && !if_flush && !prev_live_fetch) begin
                m_busy = 1; m_data = 0; m_stale = 0; m_zero = 0;
                m_we = 1'b0; m_addr = if_addr; m_be = 4'hF;
            end else begin
                m_busy = 0;
            end
        end
    endtask

    initial begin
        // rst ifq  if_addr  fl dmq we dm_addr    dm_wdata     be    ack rdata      | full req addr      we be    wdata        iv dd sp sf
        tbl[0]  = '{0, 0, 32'h000, 0, 0, 0, 32'h0000, 32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h0000, 0, 4'h0, 32'h0,        0, 0, 0, 0};
        tbl[1]  = '{0, 1, 32'h100, 0, 0, 0, 32'h0000, 32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0000, 0, 4'h0, 32'h0,        0, 0, 0, 1};
        tbl[2]  = '{0, 1, 32'h100, 0, 0, 0, 32'h0000, 32'h0,        4'h0, 0, 32'h0,        0, 1, 32'h0100, 0, 4'hF, 32'h0,        0, 0, 0, 1};
        tbl[3]  = '{0, 1, 32'h100, 0, 0, 0, 32'h0000, 32'h0,        4'h0, 0, 32'h0,        0, 1, 32'h0100, 0, 4'hF, 32'h0,        0, 0, 0, 1};
        tbl[4]  = '{0, 1, 32'h100, 0, 0, 0, 32'h0000, 32'h0,        4'h0, 1, 32'h00500093, 0, 1, 32'h0100, 0, 4'hF, 32'h0,        1, 0, 0, 0};
        tbl[5]  = '{0, 0, 32'h000, 0, 0, 0, 32'h0000, 32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0000, 0, 4'h0, 32'h0,        0, 0, 0, 0};
        tbl[6]  = '{0, 1, 32'h140, 0, 1, 0, 32'h2000, 32'h0,        4'hF, 0, 32'h0,        0, 0, 32'h0000, 0, 4'h0, 32'h0,        0, 0, 1, 1};
        tbl[7]  = '{0, 1, 32'h140, 0, 1, 0, 32'h2000, 32'h0,        4'hF, 1, 32'h12345678, 0, 1, 32'h2000, 0, 4'hF, 32'h0,        0, 1, 0, 1};
        tbl[8]  = '{0, 1, 32'h140, 0, 0, 0, 32'h0000, 32'h0,        4'h0, 1, 32'h00A00113, 0, 1, 32'h0140, 0, 4'hF, 32'h0,        1, 0, 0, 0};
        tbl[9]  = '{0, 0, 32'h000, 0, 0, 0, 32'h0000, 32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0000, 0, 4'h0, 32'h0,        0, 0, 0, 0};
        tbl[10] = '{0, 0, 32'h000, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0,        0, 0, 32'h0000, 0, 4'h0, 32'h0,        0, 0, 1, 1};
        tbl[11] = '{0, 0, 32'h000, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0,        0, 1, 32'h2004, 1, 4'h3, 32'hDEADBEEF, 0, 0, 1, 1};
        tbl[12] = '{0, 0, 32'h000, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 1, 32'h0,        0, 1, 32'h2004, 1, 4'h3, 32'hDEADBEEF, 0, 1, 0, 0};
        tbl[13] = '{0, 0, 32'h000, 0, 0, 0, 32'h0000, 32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0000, 0, 4'h0, 32'h0,        0, 0, 0, 0};
        tbl[14] = '{0, 1, 32'h180, 0, 0, 0, 32'h0000, 32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0000, 0, 4'h0, 32'h0,        0, 0, 0, 1};
        tbl[15] = '{0, 1, 32'h180, 0, 1, 0, 32'h2008, 32'h0,        4'hF, 0, 32'h0,        0, 1, 32'h0180, 0, 4'hF, 32'h0,        0, 0, 1, 1};
        tbl[16] = '{0, 1, 32'h180, 0, 1, 0, 32'h2008, 32'h0,        4'hF, 1, 32'h00100073, 0, 1, 32'h0180, 0, 4'hF, 32'h0,        1, 0, 1, 1};
        tbl[17] = '{0, 1, 32'h184, 0, 1, 0, 32'h2008, 32'h0,        4'hF, 0, 32'h0,        0, 1, 32'h2008, 0, 4'hF, 32'h0,        0, 0, 1, 1};
        tbl[18] = '{0, 1, 32'h184, 0, 1, 0, 32'h2008, 32'h0,        4'hF, 1, 32'h00000055, 0, 1, 32'h2008, 0, 4'hF, 32'h0,        0, 1, 0, 1};
        tbl[19] = '{0, 1, 32'h184, 0, 0, 0, 32'h0000, 32'h0,        4'h0, 1, 32'h00000013, 0, 1, 32'h0184, 0, 4'hF, 32'h0,        1, 0, 0, 0};
        tbl[20] = '{0, 0, 32'h000, 0, 0, 0, 32'h0000, 32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0000, 0, 4'h0, 32'h0,        0, 0, 0, 0};

        idle_inputs();
        rst = 1'b1;
        #1;
        next_cycle();
        next_cycle();

        for (int i = 0; i < 21; i++) apply_vec(tbl[i], i);

        // flush while a fetch of 0x100 is outstanding; redirect to 0x200
        idle_inputs();
        if_req = 1'b1; if_addr = 32'h100;
        #2; chk("flush_c1_mem_req", 32'(mem_req), 32'h0); next_cycle();
        #2; chk("flush_c2_mem_addr", mem_addr, 32'h100); next_cycle();
        if_flush = 1'b1; if_addr = 32'h200;
        #2; chk("flush_c3_if_valid", 32'(if_valid), 32'h0); next_cycle();
        if_flush = 1'b0;
        #2; chk("flush_c4_if_valid", 32'(if_valid), 32'h0);
        chk("flush_c4_mem_addr", mem_addr, 32'h100); next_cycle();
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        #2; chk("flush_c5_if_valid", 32'(if_valid), 32'h0);
        chk("flush_c5_mem_req", 32'(mem_req), 32'h1); next_cycle();
        mem_ack = 1'b0;
        #2; chk("flush_c6_mem_req", 32'(mem_req), 32'h1);
        chk("flush_c6_mem_addr", mem_addr, 32'h200); next_cycle();
        mem_ack = 1'b1; mem_rdata = 32'h00000013;
        #2; chk("flush_c7_if_valid", 32'(if_valid), 32'h1); next_cycle();
        idle_inputs();
        #2; chk("flush_c8_mem_req", 32'(mem_req), 32'h0); next_cycle();

        // reset in the middle of an outstanding load
        dm_req = 1'b1; dm_addr = 32'h3000; dm_wdata = 32'hA5A5A5A5; dm_be = 4'hF;
        #2; chk("rstd_c1_stall_pipe", 32'(stall_pipe), 32'h1); next_cycle();
        #2; chk("rstd_c2_mem_req", 32'(mem_req), 32'h1);
        chk("rstd_c2_mem_addr", mem_addr, 32'h3000); next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; mem_ack = 1'b1;
        #2; chk("rstd_c4_mem_req", 32'(mem_req), 32'h0);
        chk("rstd_c4_mem_addr", mem_addr, 32'h0);
        chk("rstd_c4_mem_wdata", mem_wdata, 32'h0);
        chk("rstd_c4_mem_ctl", {27'h0, mem_we, mem_be}, 32'h0);
        chk("rstd_c4_dm_done", 32'(dm_done), 32'h0); next_cycle();
        #2; chk("rstd_c5_mem_req", 32'(mem_req), 32'h1);
        chk("rstd_c5_dm_done", 32'(dm_done), 32'h1); next_cycle();
        idle_inputs();
        next_cycle();

        // randomized traffic against the model
        rst = 1'b1;
        model_reset();
        next_cycle();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom % 128) == 0;
            if_req    = ($urandom % 4) != 0;
            if_flush  = ($urandom % 8) == 0;
            if_addr   = $urandom & 32'hFFFF_FFFC;
            dm_req    = ($urandom % 3) == 0;
            dm_we     = 1'($urandom);
            dm_addr   = $urandom;
            dm_wdata  = $urandom;
            dm_be     = 4'($urandom);
            mem_rdata = $urandom;
            mem_ack   = m_busy ? (($urandom % 3) != 0) : (($urandom % 6) == 0);
            #2;
            model_check(c);
            model_step();
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
